// File: rtl/logic_exec_stage.sv
// Execute stage for the bitwise logic unit: one operand register (S1) followed by a
// small result FIFO so downstream stalls are absorbed before they back-pressure issue.
module logic_exec_stage #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [TAGW-1:0]  s1_tag_q;

  logic [WIDTH-1:0] mem_result_q [DEPTH];
  logic [TAGW-1:0]  mem_tag_q    [DEPTH];
  logic [DEPTH-1:0] mem_zero_q;
  logic [DEPTH-1:0] mem_err_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [15:0]      op_count_q;

  logic [WIDTH-1:0] res;
  logic             res_err;
  logic             res_zero;
  logic             push;
  logic             pop;
  logic             s1_adv;
  logic             accept;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (s1_op_q)
      3'b000: res = s1_a_q & s1_b_q;
      3'b001: res = s1_a_q | s1_b_q;
      3'b010: res = s1_a_q ^ s1_b_q;
      3'b011: res = ~s1_a_q;
      3'b100: res = s1_a_q;
      3'b101: res = s1_b_q;
      3'b110: res = ~(s1_a_q ^ s1_b_q);
      3'b111: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  assign res_zero  = ~|res;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A full queue still takes S1 when the head leaves on the same edge.
  assign s1_adv    = s1_valid_q && ((count_q < DepthC) || pop);
  assign push      = s1_adv;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign accept    = in_valid && in_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= in_op;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_tag_q   <= in_tag;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_result_q[i] <= '0;
        mem_tag_q[i]    <= '0;
      end
      mem_zero_q <= '0;
      mem_err_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      if (push) begin
        mem_result_q[wr_ptr_q] <= res;
        mem_tag_q[wr_ptr_q]    <= s1_tag_q;
        mem_zero_q[wr_ptr_q]   <= res_zero;
        mem_err_q[wr_ptr_q]    <= res_err;
        wr_ptr_q               <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PW'(1);
        op_count_q <= op_count_q + 16'd1;
      end
      count_q <= count_d;
    end
  end

  assign out_result = mem_result_q[rd_ptr_q];
  assign out_zero   = mem_zero_q[rd_ptr_q];
  assign out_err    = mem_err_q[rd_ptr_q];
  assign out_tag    = mem_tag_q[rd_ptr_q];
  assign busy       = s1_valid_q || (count_q != '0);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_logic_exec_stage.sv
// Scoreboard bench for logic_exec_stage: the driver queues hand-computed results on
// acceptance, a negedge monitor pops and compares every delivered result.
module tb_logic_exec_stage;

  localparam int unsigned WIDTH = 20;
  localparam int unsigned TAGW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_err;
  logic [TAGW-1:0]  out_tag;
  logic             busy;
  logic [15:0]      op_count;

  int n_cmp = 0;
  int n_bad = 0;

  // {result, zero, err, tag}
  logic [WIDTH+TAGW+1:0] sb [$];

  logic [WIDTH-1:0] sw_res [8] = '{20'h00000, 20'hFFFFF, 20'hFFFFF, 20'h55555,
                                   20'hAAAAA, 20'h55555, 20'h00000, 20'h00000};
  logic [7:0] sw_z   = 8'b1100_0001;
  logic [7:0] sw_err = 8'b1000_0000;

  logic_exec_stage #(.WIDTH(WIDTH), .DEPTH(2), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .out_tag    (out_tag),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a head seen with out_ready high at negedge is popped on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got res=%h tag=%h, expected nothing queued",
                 out_result, out_tag);
      end else begin
        logic [WIDTH+TAGW+1:0] e;
        e = sb.pop_front();
        if ({out_result, out_zero, out_err, out_tag} !== e) begin
          n_bad++;
          $display("FAIL result_fifo: got res=%h z=%b err=%b tag=%h, expected res=%h z=%b err=%b tag=%h",
                   out_result, out_zero, out_err, out_tag,
                   e[WIDTH+TAGW+1:TAGW+2], e[TAGW+1], e[TAGW], e[TAGW-1:0]);
        end
      end
    end
  end

  // Drive one op, wait (bounded) for acceptance, queue its expected response.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag,
                       input logic [WIDTH-1:0] eres, input logic ez, input logic eerr,
                       output int waited);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for tag %0h, expected acceptance", tag);
    end else begin
      sb.push_back({eres, ez, eerr, tag});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cycles = 0;
    while ((sb.size() != 0 || busy) && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    n_cmp++;
    if (cycles >= 200) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries pending busy=%b, expected empty",
               sb.size(), busy);
    end
  endtask

  initial begin
    int w;
    int tot;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);
    chk("reset_out_result", 32'(out_result), 32'd0);
    chk("reset_out_flags", {30'd0, out_zero, out_err}, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    #16 rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single op and latency
    out_ready = 1'b1;
    issue(3'b000, 20'hF0F0F, 20'h0FF0F, 4'd3, 20'h00F0F, 1'b0, 1'b0, w);
    chk("latency_in_s1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_head", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("single_op_count", 32'(op_count), 32'd1);

    // Opcode sweep, back-to-back
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 20'hAAAAA, 20'h55555, 4'(i), sw_res[i], sw_z[i], sw_err[i], w);
      tot += w;
    end
    chk("sweep_stalls", 32'(tot), 32'd0);
    drain();
    chk("sweep_op_count", 32'(op_count), 32'd9);

    // Backpressure: two queued plus S1, fourth stalls
    out_ready = 1'b0;
    issue(3'b000, 20'h12345, 20'h0F0F0, 4'd0, 20'h02040, 1'b0, 1'b0, w);
    issue(3'b001, 20'h12345, 20'h0F0F0, 4'd1, 20'h1F3F5, 1'b0, 1'b0, w);
    issue(3'b011, 20'h12345, 20'h0F0F0, 4'd2, 20'hEDCBA, 1'b0, 1'b0, w);
    in_valid = 1'b1;
    in_op    = 3'b110;
    in_a     = 20'h12345;
    in_b     = 20'h12345;
    in_tag   = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_head_tag", 32'(out_tag), 32'd0);
      chk("stall_head_result", 32'(out_result), 32'h02040);
      chk("stall_head_valid", 32'(out_valid), 32'd1);
    end
    // Full queue, one-cycle release: pop and push on the same edge
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pushpop_ready", 32'(in_ready), 32'd1);
    sb.push_back({20'hFFFFF, 1'b0, 1'b0, 4'd3});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("still_full_ready", 32'(in_ready), 32'd0);
    chk("still_full_head", 32'(out_tag), 32'd1);
    chk("still_full_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("bp_op_count", 32'(op_count), 32'd13);

    // Asynchronous reset with three ops in flight
    out_ready = 1'b0;
    issue(3'b100, 20'h00005, 20'h0, 4'd5, 20'h00005, 1'b0, 1'b0, w);
    issue(3'b100, 20'h00006, 20'h0, 4'd6, 20'h00006, 1'b0, 1'b0, w);
    issue(3'b100, 20'h00007, 20'h0, 4'd7, 20'h00007, 1'b0, 1'b0, w);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_op_count", 32'(op_count), 32'd0);
    sb.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(3'b100, 20'h0ABCD, 20'h11111, 4'd9, 20'h0ABCD, 1'b0, 1'b0, w);
    drain();
    chk("post_rst_op_count", 32'(op_count), 32'd1);

    // op_count wrap after 65537 deliveries
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 65537; i++) begin
      issue(3'b101, 20'h0F0F0, 20'h00001, 4'(i), 20'h00001, 1'b0, 1'b0, w);
    end
    drain();
    chk("op_count_wrap", 32'(op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
